// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the TinyRISC-V instruction-fetch front end.
package if_fetch_queue_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned IMEM_RESP_W = 32;

   localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One instruction-queue entry as presented to decode
   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic [IMEM_RESP_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Synchronous queue with push/pop/flush; head is read straight from the entry registers.
module if_fetch_queue_sync_fifo #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && !full;
   assign rdata   = mem[rd_ptr];

   // Pointer wrap also covers non power-of-two depths
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
      end else if (do_push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, imem req/gnt/rvalid, instruction queue to ID.
// Optional FETCH_PERF_EN adds fetch/bubble performance counters.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int unsigned     DEPTH           = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_o,
   output logic [XLEN-1:0]        imem_addr_o,
   input  logic                   imem_gnt_i,
   input  logic                   imem_rvalid_i,
   input  logic [IMEM_RESP_W-1:0] imem_rdata_i,
   input  logic                   redirect_i,
   input  logic [XLEN-1:0]        redirect_pc_i,
   output logic                   id_valid_o,
   output logic [IMEM_RESP_W-1:0] id_inst_o,
   output logic [XLEN-1:0]        id_pc_o,
   input  logic                   id_ready_i
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]            perf_fetch_cnt_o,
   output logic [31:0]            perf_bubble_cnt_o
`endif
);

   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned SUM_W  = CNT_W + 1;
   localparam int unsigned DROP_W = 8;

   logic [XLEN-1:0]   fetch_pc;
   logic [OUT_W-1:0]  outstanding;
   logic [DROP_W-1:0] drop_cnt;

   logic              grant;
   logic              resp_drop;
   logic              resp_accept;
   logic              inst_push;
   logic              inst_pop;
   logic [CNT_W-1:0]  inst_count;
   logic              inst_empty;
   logic              inst_full;
   fetch_entry_t      inst_wdata;
   fetch_entry_t      inst_head;
   logic [XLEN-1:0]   tag_head;
   logic [OUT_W-1:0]  tag_count;
   logic              tag_empty;
   logic              tag_full;

   // Credit covers queued plus in-flight entries so a response always finds room
   assign imem_req_o  = !rst && !redirect_i
                        && ((SUM_W'(inst_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH))
                        && (outstanding < OUT_W'(MAX_OUTSTANDING));
   assign imem_addr_o = fetch_pc;
   assign grant       = imem_req_o && imem_gnt_i;

   // Responses owed to a flushed fetch stream are consumed by drop_cnt first
   assign resp_drop   = imem_rvalid_i && (drop_cnt != '0);
   assign resp_accept = imem_rvalid_i && (drop_cnt == '0) && (outstanding != '0);
   assign inst_push   = resp_accept && !redirect_i;

   assign id_valid_o  = !inst_empty && !redirect_i;
   assign inst_pop    = id_valid_o && id_ready_i;
   assign id_inst_o   = inst_head.inst;
   assign id_pc_o     = inst_head.pc;
   assign inst_wdata  = '{pc: tag_head, inst: imem_rdata_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (redirect_i) begin
         fetch_pc    <= word_align(redirect_pc_i);
         outstanding <= '0;
         drop_cnt    <= drop_cnt + DROP_W'(outstanding) - DROP_W'(resp_drop || resp_accept);
      end else begin
         if (grant) fetch_pc <= fetch_pc + 32'd4;
         outstanding <= outstanding + OUT_W'(grant) - OUT_W'(resp_accept);
         if (resp_drop) drop_cnt <= drop_cnt - DROP_W'(1);
      end
   end

   if_fetch_queue_sync_fifo #(
      .WIDTH     (XLEN),
      .DEPTH     (MAX_OUTSTANDING),
      .RESET_VAL ('0)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (grant),
      .wdata (fetch_pc),
      .pop   (resp_accept),
      .flush (redirect_i),
      .rdata (tag_head),
      .count (tag_count),
      .empty (tag_empty),
      .full  (tag_full)
   );

   if_fetch_queue_sync_fifo #(
      .WIDTH     ($bits(fetch_entry_t)),
      .DEPTH     (DEPTH),
      .RESET_VAL (fetch_entry_t'{pc: '0, inst: INST_NOP})
   ) u_inst_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inst_push),
      .wdata (inst_wdata),
      .pop   (inst_pop),
      .flush (redirect_i),
      .rdata (inst_head),
      .count (inst_count),
      .empty (inst_empty),
      .full  (inst_full)
   );

`ifdef FETCH_PERF_EN
   // Instructions handed to ID, and cycles ID wanted one but none was offered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt_o  <= '0;
         perf_bubble_cnt_o <= '0;
      end else begin
         if (inst_pop)                 perf_fetch_cnt_o  <= perf_fetch_cnt_o + 32'd1;
         if (id_ready_i && !id_valid_o) perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
      end
   end
`else
   // Performance counters are compiled out of this build.
`endif

   a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
      !(imem_rvalid_i && (outstanding == '0) && (drop_cnt == '0)));
   a_tag_tracks_credit: assert property (@(posedge clk) disable iff (rst)
      (tag_count == outstanding) && !(resp_accept && tag_empty) && !(grant && tag_full));
   a_inst_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(inst_push && inst_full));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a transaction-level model of the fetch stream.
module tb_if_fetch_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned MAXO   = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        id_valid_o;
   logic [31:0] id_inst_o;
   logic [31:0] id_pc_o;
   logic        id_ready_i;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;
   logic [31:0] pf_fetch;
   logic [31:0] pf_bubble;
`endif

   if_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .id_valid_o    (id_valid_o),
      .id_inst_o     (id_inst_o),
      .id_pc_o       (id_pc_o),
      .id_ready_i    (id_ready_i)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt_o  (perf_fetch_cnt),
      .perf_bubble_cnt_o (perf_bubble_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory side: each granted request, tagged with the fetch stream (epoch) it belongs to
   typedef struct {
      logic [31:0] addr;
      logic [31:0] pc;
      int          epoch;
      int          due;
   } mreq_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   mreq_t       memq[$];
   ent_t        mq[$];
   int          out_m;
   int          epoch;
   int          cyc;
   int          n_chk;
   int          n_pass;
   int          n_grants;
   logic [31:0] exp_pc;

   bit k_gnt;
   bit k_ready;
   int k_lat;
   int k_rv_pct;

   logic        cap_req;
   logic        cap_valid;
   logic        cap_rv;
   logic [31:0] cap_addr;
   logic [31:0] cap_pc;
   logic [31:0] cap_inst;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // One clock cycle, entered and left at posedge+1
   task automatic step(input bit redir, input logic [31:0] tgt);
      bit    exp_req;
      bit    exp_valid;
      bit    accepted;
      bit    rv;
      mreq_t e;
      e = '{addr: '0, pc: '0, epoch: 0, due: 0};
      imem_gnt_i    = k_gnt;
      id_ready_i    = k_ready;
      redirect_i    = redir;
      redirect_pc_i = tgt;
      rv = (memq.size() != 0) && (memq[0].due <= cyc) && (int'($urandom_range(99)) < k_rv_pct);
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_data(memq[0].addr) : $urandom;
      @(negedge clk);
      exp_req   = !redir && (mq.size() + out_m < int'(DEPTH)) && (out_m < int'(MAXO));
      exp_valid = (mq.size() != 0) && !redir;
      chk("imem_req", 32'(imem_req_o), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr_o, exp_pc);
      chk("id_valid", 32'(id_valid_o), 32'(exp_valid));
      if (exp_valid) begin
         chk("id_pc", id_pc_o, mq[0].pc);
         chk("id_inst", id_inst_o, mq[0].inst);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, pf_fetch);
      chk("perf_bubble", perf_bubble_cnt, pf_bubble);
      if (exp_valid && k_ready) pf_fetch++;
      if (k_ready && !exp_valid) pf_bubble++;
`endif
      cap_req   = imem_req_o;
      cap_addr  = imem_addr_o;
      cap_valid = id_valid_o;
      cap_pc    = id_pc_o;
      cap_inst  = id_inst_o;
      cap_rv    = rv;
      accepted  = 1'b0;
      if (rv) begin
         e = memq.pop_front();
         accepted = !redir && (e.epoch == epoch);
      end
      if (exp_valid && k_ready) void'(mq.pop_front());
      if (accepted) begin
         mq.push_back('{pc: e.pc, inst: mem_data(e.addr)});
         out_m--;
      end
      if (imem_req_o && imem_gnt_i) begin
         memq.push_back('{addr: imem_addr_o, pc: exp_pc, epoch: epoch, due: cyc + k_lat});
         n_grants++;
      end
      if (exp_req && k_gnt) begin
         exp_pc += 32'd4;
         out_m++;
      end
      if (redir) begin
         mq.delete();
         out_m  = 0;
         epoch++;
         exp_pc = {tgt[31:2], 2'b00};
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Asynchronous reset with outputs checked immediately, responses pulsed while held
   task automatic do_reset();
      redirect_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      rst           = 1'b1;
      #1;
      chk("rst_req", 32'(imem_req_o), 32'h0);
      chk("rst_addr", imem_addr_o, RST_PC);
      chk("rst_valid", 32'(id_valid_o), 32'h0);
      chk("rst_inst", id_inst_o, NOP);
      chk("rst_pc", id_pc_o, 32'h0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
      chk("rst_perf_bubble", perf_bubble_cnt, 32'h0);
      pf_fetch  = '0;
      pf_bubble = '0;
`endif
      repeat (3) begin
         @(posedge clk);
         #1;
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = $urandom;
      end
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      memq.delete();
      mq.delete();
      out_m  = 0;
      epoch++;
      exp_pc = RST_PC;
      rst    = 1'b0;
   endtask

   initial begin
      bit found;
      n_chk = 0; n_pass = 0; cyc = 0; epoch = 0; out_m = 0; n_grants = 0;
      k_gnt = 1'b1; k_ready = 1'b1; k_lat = 1; k_rv_pct = 100;
      exp_pc = RST_PC;
      rst = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
      #1;
      do_reset();

      // Streaming: one fetch per cycle, ID sees 0,4,8 after two cycles
      for (int i = 0; i < 5; i++) begin
         step(1'b0, '0);
         if (i < 3) chk("t1_addr", cap_addr, 32'(4 * i));
         if (i == 2) chk("t1_inst", cap_inst, mem_data(32'h0));
         if (i >= 2) chk("t1_pc", cap_pc, 32'(4 * (i - 2)));
      end

      // Back-pressure: queue fills after DEPTH grants, then drains in order
      do_reset();
      k_ready = 1'b0;
      n_grants = 0;
      repeat (10) step(1'b0, '0);
      chk("t2_grants", 32'(n_grants), 32'd4);
      chk("t2_req_off", 32'(cap_req), 32'h0);
      chk("t2_head_pc", cap_pc, 32'h0);
      chk("t2_next_addr", cap_addr, 32'h10);
      k_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0);
         chk("t2_drain_pc", cap_pc, 32'(4 * i));
         if (i == 1) chk("t2_resume", cap_req ? cap_addr : 32'hDEAD_BEEF, 32'h10);
      end

      // Redirect with two requests in flight
      do_reset();
      k_lat = 4;
      repeat (3) step(1'b0, '0);
      step(1'b1, 32'h0000_0103);
      step(1'b0, '0);
      chk("t3_addr_r1", cap_req ? cap_addr : 32'hDEAD_BEEF, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1'b0, '0);
         if (cap_valid) begin
            found = 1'b1;
            chk("t3_first_pc", cap_pc, 32'h100);
         end
      end
      if (!found) fail_now("t3_first_pc");

      // Redirect colliding with a response while the queue holds an entry
      do_reset();
      k_lat = 1;
      k_ready = 1'b0;
      repeat (2) step(1'b0, '0);
      step(1'b1, 32'h0000_0200);
      chk("t4_valid_r", 32'(cap_valid), 32'h0);
      chk("t4_rvalid_r", 32'(cap_rv), 32'h1);
      k_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1'b0, '0);
         if (cap_valid) begin
            found = 1'b1;
            chk("t4_first_pc", cap_pc, 32'h200);
         end
      end
      if (!found) fail_now("t4_first_pc");

      // Fetch address wraps past the top of memory
      step(1'b1, 32'hFFFF_FFF8);
      step(1'b0, '0);
      chk("t5_wrap0", cap_req ? cap_addr : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
      step(1'b0, '0);
      chk("t5_wrap1", cap_req ? cap_addr : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      step(1'b0, '0);
      chk("t5_wrap2", cap_req ? cap_addr : 32'hDEAD_BEEF, 32'h0000_0000);

      // Reset with queued entries and requests in flight
      do_reset();
      k_ready = 1'b0;
      k_lat = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, '0);
         found = (mq.size() == 2) && (out_m == 2);
      end
      if (!found) fail_now("t6_reach_busy");
      do_reset();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         k_gnt    = ($urandom_range(3) != 0);
         k_ready  = ($urandom_range(9) < 7);
         k_lat    = int'($urandom_range(1, 3));
         k_rv_pct = 75;
         step($urandom_range(19) == 0, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
